cargo_scheduler: RTL

- Request scheduler for the smart cargo elevator. It sits between the serial/request-decode path and the movement control unit.
- It stores up to N_PEDIDOS pending transport orders, each an origin floor plus a destination floor, and tracks each order as waiting or loaded.
- It chooses the next stop with a SCAN policy (keep moving in the current direction while stops remain ahead) and presents that stop with a valid flag.
- It retires orders when the movement unit reports that service at a floor is complete.

---
 rtl/cargo_sched_pkg.sv | 24 ++
 rtl/cargo_alvo_scan.sv | 74 +++++++
 rtl/cargo_scheduler.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cargo_sched_pkg.sv
// Shared types for the cargo elevator request scheduler.
//   estado_t  : scheduler FSM state, encoded as the db_estado debug code
//   slot_st_t : life cycle of one order slot
package cargo_sched_pkg;

  localparam int unsigned ESTADO_W = 4;
  localparam int unsigned OCUP_W   = 4;

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL  = 4'd0,
    OCIOSO   = 4'd1,
    REGISTRA = 4'd2,
    CALCULA  = 4'd3,
    AGUARDA  = 4'd4,
    ATENDE   = 4'd5
  } estado_t;

  typedef enum logic [1:0] {
    LIVRE     = 2'd0,
    ESPERA    = 2'd1,
    CARREGADO = 2'd2
  } slot_st_t;

endpackage

// File: rtl/cargo_alvo_scan.sv
// SCAN stop selection (combinational).
//   alvo          : one bit per floor that currently needs a stop
//   andar_atual   : floor the car is at
//   sobe          : current travel direction, 1 = up
//   alvo_valido_c : at least one floor is requested
//   alvo_andar_c  : chosen stop
//   novo_sobe_c   : direction after the choice (flips only on reversal)
module cargo_alvo_scan
  import cargo_sched_pkg::*;
#(
  parameter int unsigned ANDAR_W = 2
) (
  input  logic [(2**ANDAR_W)-1:0] alvo,
  input  logic [ANDAR_W-1:0]      andar_atual,
  input  logic                    sobe,
  output logic                    alvo_valido_c,
  output logic [ANDAR_W-1:0]      alvo_andar_c,
  output logic                    novo_sobe_c
);

  localparam int unsigned N_ANDARES = 2**ANDAR_W;

  logic               acima_ok;
  logic               abaixo_ok;
  logic [ANDAR_W-1:0] acima;
  logic [ANDAR_W-1:0] abaixo;

  // Nearest requested floor on each side of the car.
  always_comb begin
    acima_ok  = 1'b0;
    abaixo_ok = 1'b0;
    acima     = '0;
    abaixo    = '0;
    // Descending walk so the last hit is the lowest floor above the car.
    for (int i = int'(N_ANDARES) - 1; i >= 0; i--) begin
      if (i > int'(andar_atual) && alvo[i]) begin
        acima_ok = 1'b1;
        acima    = ANDAR_W'(i);
      end
    end
    // Ascending walk so the last hit is the highest floor below the car.
    for (int i = 0; i < int'(N_ANDARES); i++) begin
      if (i < int'(andar_atual) && alvo[i]) begin
        abaixo_ok = 1'b1;
        abaixo    = ANDAR_W'(i);
      end
    end
  end

  // Keep direction while stops remain ahead, otherwise reverse.
  always_comb begin
    alvo_valido_c = |alvo;
    alvo_andar_c  = andar_atual;
    novo_sobe_c   = sobe;
    if (!alvo[andar_atual]) begin
      if (sobe) begin
        if (acima_ok) begin
          alvo_andar_c = acima;
        end else begin
          alvo_andar_c = abaixo;
          novo_sobe_c  = 1'b0;
        end
      end else begin
        if (abaixo_ok) begin
          alvo_andar_c = abaixo;
        end else begin
          alvo_andar_c = acima;
          novo_sobe_c  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cargo_scheduler.sv
// Order scheduler for the cargo elevator: stores pickup/drop orders, picks the
// next stop with a SCAN policy and retires orders as stops are served.
//   clock, reset              : clock, synchronous active-high reset
//   novo_pedido, pedido_*     : new order (origin, destination) strobe
//   andar_atual               : current floor
//   servico_concluido         : stop at prox_parada fully served
//   pedido_aceito/rejeitado   : order stored / dropped pulses
//   prox_parada, tem_destino  : next stop and its valid flag
//   sobe, eh_origem           : direction, stop includes a pickup
//   ocupacao, db_estado       : slots in use, FSM state code
module cargo_scheduler
  import cargo_sched_pkg::*;
#(
  parameter int unsigned N_PEDIDOS = 4,
  parameter int unsigned ANDAR_W   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                novo_pedido,
  input  logic [ANDAR_W-1:0]  pedido_origem,
  input  logic [ANDAR_W-1:0]  pedido_destino,
  input  logic [ANDAR_W-1:0]  andar_atual,
  input  logic                servico_concluido,
  output logic                pedido_aceito,
  output logic                pedido_rejeitado,
  output logic [ANDAR_W-1:0]  prox_parada,
  output logic                tem_destino,
  output logic                sobe,
  output logic                eh_origem,
  output logic [OCUP_W-1:0]   ocupacao,
  output logic [ESTADO_W-1:0] db_estado
);

  localparam int unsigned N_ANDARES = 2**ANDAR_W;

  estado_t            estado_q, estado_d;
  slot_st_t           slot_st_q  [N_PEDIDOS];
  slot_st_t           slot_st_d  [N_PEDIDOS];
  logic [ANDAR_W-1:0] slot_org_q [N_PEDIDOS];
  logic [ANDAR_W-1:0] slot_org_d [N_PEDIDOS];
  logic [ANDAR_W-1:0] slot_dst_q [N_PEDIDOS];
  logic [ANDAR_W-1:0] slot_dst_d [N_PEDIDOS];

  logic               hold_cheio_q, hold_cheio_d;
  logic [ANDAR_W-1:0] hold_org_q, hold_org_d;
  logic [ANDAR_W-1:0] hold_dst_q, hold_dst_d;

  logic               aceito_q, aceito_d;
  logic               rejeitado_q, rejeitado_d;
  logic [ANDAR_W-1:0] prox_q, prox_d;
  logic               tem_destino_q, tem_destino_d;
  logic               sobe_q, sobe_d;
  logic               eh_origem_q, eh_origem_d;
  logic [OCUP_W-1:0]  ocup_q, ocup_d;

  logic [N_ANDARES-1:0] alvo;
  logic                 alvo_valido_c;
  logic [ANDAR_W-1:0]   alvo_andar_c;
  logic                 novo_sobe_c;
  logic                 pega_aqui;
  logic                 gravado;

  // Floors needing a stop: pickups of waiting orders, drops of loaded ones.
  always_comb begin
    alvo = '0;
    for (int i = 0; i < int'(N_PEDIDOS); i++) begin
      if (slot_st_q[i] == ESPERA)    alvo[slot_org_q[i]] = 1'b1;
      if (slot_st_q[i] == CARREGADO) alvo[slot_dst_q[i]] = 1'b1;
    end
  end

  cargo_alvo_scan #(
    .ANDAR_W (ANDAR_W)
  ) u_scan (
    .alvo          (alvo),
    .andar_atual   (andar_atual),
    .sobe          (sobe_q),
    .alvo_valido_c (alvo_valido_c),
    .alvo_andar_c  (alvo_andar_c),
    .novo_sobe_c   (novo_sobe_c)
  );

  // Chosen stop includes at least one pickup.
  always_comb begin
    pega_aqui = 1'b0;
    for (int i = 0; i < int'(N_PEDIDOS); i++) begin
      if (slot_st_q[i] == ESPERA && slot_org_q[i] == alvo_andar_c) pega_aqui = 1'b1;
    end
  end

  // Next-state, slot updates and registered outputs.
  always_comb begin
    estado_d     = estado_q;
    slot_st_d    = slot_st_q;
    slot_org_d   = slot_org_q;
    slot_dst_d   = slot_dst_q;
    hold_cheio_d = hold_cheio_q;
    hold_org_d   = hold_org_q;
    hold_dst_d   = hold_dst_q;
    aceito_d     = 1'b0;
    rejeitado_d  = 1'b0;
    prox_d       = prox_q;
    sobe_d       = sobe_q;
    eh_origem_d  = eh_origem_q;
    gravado      = 1'b0;

    // Single-entry holding register; a new order while it is full is lost.
    if (novo_pedido) begin
      if (!hold_cheio_q) begin
        hold_cheio_d = 1'b1;
        hold_org_d   = pedido_origem;
        hold_dst_d   = pedido_destino;
      end else begin
        rejeitado_d = 1'b1;
      end
    end

    unique case (estado_q)
      INICIAL: estado_d = OCIOSO;
      OCIOSO: begin
        if (hold_cheio_q) estado_d = REGISTRA;
      end
      REGISTRA: begin
        if (hold_org_q != hold_dst_q) begin
          for (int i = 0; i < int'(N_PEDIDOS); i++) begin
            if (!gravado && slot_st_q[i] == LIVRE) begin
              slot_st_d[i]  = ESPERA;
              slot_org_d[i] = hold_org_q;
              slot_dst_d[i] = hold_dst_q;
              gravado       = 1'b1;
            end
          end
        end
        if (gravado) aceito_d    = 1'b1;
        else         rejeitado_d = 1'b1;
        hold_cheio_d = 1'b0;
        estado_d     = CALCULA;
      end
      CALCULA: begin
        if (alvo_valido_c) begin
          prox_d      = alvo_andar_c;
          sobe_d      = novo_sobe_c;
          eh_origem_d = pega_aqui;
          estado_d    = AGUARDA;
        end else begin
          estado_d = OCIOSO;
        end
      end
      AGUARDA: begin
        if (servico_concluido) estado_d = ATENDE;
        else if (hold_cheio_q) estado_d = REGISTRA;
      end
      ATENDE: begin
        // Drops and pickups at this floor resolve together, no chaining.
        for (int i = 0; i < int'(N_PEDIDOS); i++) begin
          if (slot_st_q[i] == CARREGADO && slot_dst_q[i] == prox_q) begin
            slot_st_d[i] = LIVRE;
          end else if (slot_st_q[i] == ESPERA && slot_org_q[i] == prox_q) begin
            slot_st_d[i] = CARREGADO;
          end
        end
        estado_d = hold_cheio_q ? REGISTRA : CALCULA;
      end
      default: estado_d = INICIAL;
    endcase

    tem_destino_d = (estado_d == AGUARDA);

    ocup_d = '0;
    for (int i = 0; i < int'(N_PEDIDOS); i++) begin
      if (slot_st_d[i] != LIVRE) ocup_d = ocup_d + OCUP_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q      <= INICIAL;
      hold_cheio_q  <= 1'b0;
      hold_org_q    <= '0;
      hold_dst_q    <= '0;
      aceito_q      <= 1'b0;
      rejeitado_q   <= 1'b0;
      prox_q        <= '0;
      tem_destino_q <= 1'b0;
      sobe_q        <= 1'b1;
      eh_origem_q   <= 1'b0;
      ocup_q        <= '0;
      for (int i = 0; i < int'(N_PEDIDOS); i++) begin
        slot_st_q[i]  <= LIVRE;
        slot_org_q[i] <= '0;
        slot_dst_q[i] <= '0;
      end
    end else begin
      estado_q      <= estado_d;
      hold_cheio_q  <= hold_cheio_d;
      hold_org_q    <= hold_org_d;
      hold_dst_q    <= hold_dst_d;
      aceito_q      <= aceito_d;
      rejeitado_q   <= rejeitado_d;
      prox_q        <= prox_d;
      tem_destino_q <= tem_destino_d;
      sobe_q        <= sobe_d;
      eh_origem_q   <= eh_origem_d;
      ocup_q        <= ocup_d;
      slot_st_q     <= slot_st_d;
      slot_org_q    <= slot_org_d;
      slot_dst_q    <= slot_dst_d;
    end
  end

  assign pedido_aceito    = aceito_q;
  assign pedido_rejeitado = rejeitado_q;
  assign prox_parada      = prox_q;
  assign tem_destino      = tem_destino_q;
  assign sobe             = sobe_q;
  assign eh_origem        = eh_origem_q;
  assign ocupacao         = ocup_q;
  assign db_estado        = estado_q;

endmodule
